// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter that shares one 3-to-8 active-low
// select decoder among 8 requesters. The grant index (decoder A2..A0) and the
// decoded one-hot select are both registered. A grant ends when the owner
// finishes, drops its request, or uses up MAX_HOLD cycles. At least one idle
// cycle always separates two grants (break-before-make on sel_n).
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic [7:0] sel_n,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Last hold count of a grant; on this cycle the grant is forced to end.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q,       state_d;
    logic [2:0]        ptr_q,         ptr_d;
    logic [2:0]        grant_idx_q,   grant_idx_d;
    logic              grant_valid_q, grant_valid_d;
    logic [7:0]        sel_n_q,       sel_n_d;
    logic              timeout_q,     timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;

    logic [2:0] winner;
    logic       winner_found;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_limit;

    // Round-robin scan: first set request at ptr, ptr+1, ... ptr+7 (mod 8).
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the block leaves it unassigned and no latch is inferred.
        winner       = 3'd0;
        winner_found = 1'b0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr_q + 3'(k)]) begin
                winner       = ptr_q + 3'(k);
                winner_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        sel_n_d       = sel_n_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;

        rel_done  = done;
        rel_drop  = ~req[grant_idx_q];
        rel_limit = (hold_cnt_q == HOLD_LAST);

        unique case (state_q)
            IDLE: begin
                if (winner_found) begin
                    grant_idx_d   = winner;
                    grant_valid_d = 1'b1;
                    sel_n_d       = ~(8'b1 << winner);
                    hold_cnt_d    = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (rel_done || rel_drop || rel_limit) begin
                    // grant_idx keeps the last owner; only valid/select drop.
                    grant_valid_d = 1'b0;
                    sel_n_d       = 8'hFF;
                    ptr_d         = grant_idx_q + 3'd1;
                    hold_cnt_d    = '0;
                    // A timeout is reported only when the limit alone ended it.
                    timeout_d     = rel_limit && !rel_done && !rel_drop;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= 3'd0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            sel_n_q       <= 8'hFF;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            sel_n_q       <= sel_n_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign sel_n       = sel_n_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the arbitration rules.
module tb_rr_decode_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic [7:0] sel_n;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner is -1 while nobody holds the grant.
    int m_owner   = -1;
    int m_last    = 0;
    int m_ptr     = 0;
    int m_elapsed = 0;
    bit m_timeout = 1'b0;

    rr_decode_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .sel_n       (sel_n),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] onehot_low(input int idx);
        logic [7:0] v;
        v = 8'h01;
        return ~(v << idx);
    endfunction

    // Applies one clock edge of the arbitration rules to the model.
    task automatic model_step();
        bit ended;
        if (reset) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_elapsed = 0; m_timeout = 0;
        end else if (m_owner < 0) begin
            m_timeout = 0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                    m_owner   = (m_ptr + k) % 8;
                    m_last    = m_owner;
                    m_elapsed = 1;
                end
            end
        end else begin
            ended = done || !req[m_owner] || (m_elapsed == MAX_HOLD);
            if (ended) begin
                m_timeout = !done && req[m_owner];
                m_ptr     = (m_owner + 1) % 8;
                m_owner   = -1;
            end else begin
                m_timeout = 0;
                m_elapsed++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 8'hFF; done = 1'b0;
        tick(); tick();
        n_checks++;
        if (sel_n !== 8'hFF) begin n_fail++; $display("FAIL reset_sel_n got=%h exp=ff", sel_n); end
        n_checks++;
        if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        n_checks++;
        if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    endtask

    task automatic test_single_req();
        reset = 1'b0; req = 8'h08;
        tick();
        n_checks++;
        if (grant_idx !== 3'd3 || sel_n !== 8'hF7 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant got idx=%0d sel=%h v=%b exp idx=3 sel=f7 v=1",
                     grant_idx, sel_n, grant_valid);
        end
        req = 8'h00;
        tick();
        n_checks++;
        if (grant_valid !== 1'b0 || sel_n !== 8'hFF || timeout !== 1'b0 || grant_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL single_drop got v=%b sel=%h to=%b idx=%0d exp v=0 sel=ff to=0 idx=3",
                     grant_valid, sel_n, timeout, grant_idx);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1; tick();
        reset = 1'b0; req = 8'hFF; done = 1'b1;
        for (int g = 0; g < 9; g++) begin
            tick();
            n_checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 3'(g % 8) || sel_n !== onehot_low(g % 8)) begin
                n_fail++;
                $display("FAIL rr_grant%0d got v=%b idx=%0d sel=%h exp v=1 idx=%0d sel=%h",
                         g, grant_valid, grant_idx, sel_n, g % 8, onehot_low(g % 8));
            end
            tick();
            n_checks++;
            if (grant_valid !== 1'b0 || sel_n !== 8'hFF) begin
                n_fail++;
                $display("FAIL rr_gap%0d got v=%b sel=%h exp v=0 sel=ff", g, grant_valid, sel_n);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        req = 8'h20;
        tick();
        for (int c = 0; c < MAX_HOLD; c++) begin
            n_checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got v=%b idx=%0d to=%b exp v=1 idx=5 to=0",
                         c, grant_valid, grant_idx, timeout);
            end
            tick();
        end
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1 || sel_n !== 8'hFF) begin
            n_fail++;
            $display("FAIL timeout_pulse got v=%b to=%b sel=%h exp v=0 to=1 sel=ff",
                     grant_valid, timeout, sel_n);
        end
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL regrant got v=%b idx=%0d to=%b exp v=1 idx=5 to=0",
                     grant_valid, grant_idx, timeout);
        end
        // Requester 6 joins mid-grant; it must wait for the next IDLE.
        req = 8'h60;
        for (int c = 0; c < MAX_HOLD; c++) tick();
        n_checks++;
        if (timeout !== 1'b1 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout2 got to=%b v=%b exp to=1 v=0", timeout, grant_valid);
        end
        tick();
        n_checks++;
        if (grant_idx !== 3'd6 || grant_valid !== 1'b1 || sel_n !== 8'hBF) begin
            n_fail++;
            $display("FAIL next_after_timeout got idx=%0d v=%b sel=%h exp idx=6 v=1 sel=bf",
                     grant_idx, grant_valid, sel_n);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_simultaneous_release();
        req = 8'h04;
        tick();
        for (int c = 0; c < MAX_HOLD - 1; c++) tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_pre got v=%b idx=%0d exp v=1 idx=2", grant_valid, grant_idx);
        end
        done = 1'b1; req = 8'h00;
        tick();
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0 || sel_n !== 8'hFF) begin
            n_fail++;
            $display("FAIL simul_release got v=%b to=%b sel=%h exp v=0 to=0 sel=ff",
                     grant_valid, timeout, sel_n);
        end
        done = 1'b0;
        tick();
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL simul_quiet got to=%b exp 0", timeout); end
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h04;
        tick();
        n_checks++;
        if (grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got idx=%0d v=%b exp idx=2 v=1", grant_idx, grant_valid);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (sel_n !== 8'hFF || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_drop got sel=%h v=%b exp sel=ff v=0", sel_n, grant_valid);
        end
        reset = 1'b0; req = 8'h05;
        tick();
        n_checks++;
        if (grant_idx !== 3'd0 || sel_n !== 8'hFE) begin
            n_fail++;
            $display("FAIL midrst_ptr got idx=%0d sel=%h exp idx=0 sel=fe", grant_idx, sel_n);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_sel;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0)
                req = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            done  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            exp_sel = (m_owner >= 0) ? onehot_low(m_owner) : 8'hFF;
            n_checks++;
            if (grant_valid !== (m_owner >= 0) || grant_idx !== 3'(m_last) ||
                sel_n !== exp_sel || timeout !== m_timeout) begin
                n_fail++;
                $display("FAIL random%0d got v=%b idx=%0d sel=%h to=%b exp v=%b idx=%0d sel=%h to=%b",
                         n, grant_valid, grant_idx, sel_n, timeout,
                         (m_owner >= 0), m_last, exp_sel, m_timeout);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        test_reset();
        test_single_req();
        test_round_robin();
        test_timeout();
        test_simultaneous_release();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
